// File: rtl/mac_operand_packer.sv
// Packs up to N (a, b) operand pairs into one 2*W*N-bit frame for mult_accumulate.
// Frames may close early on in_last (upper slots zero) and stream back-to-back.
module mac_operand_packer #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_a,
  input  logic [W-1:0]           in_b,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*W*N-1:0]       out_data,
  output logic [$clog2(N):0]     out_count
);

  localparam int CW = $clog2(N) + 1;
  localparam int SW = 2 * W;
  localparam int FW = SW * N;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] ONE_IDX  = CW'(1);
  localparam logic [CW-1:0] ZERO_IDX = {CW{1'b0}};
  localparam logic          SINGLE   = (N == 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state_r;
  logic [CW-1:0]  idx_r;
  logic [FW-1:0]  data_r;
  logic [CW-1:0]  count_r;
  logic           valid_r;

  logic           accept_s;
  logic           take_s;
  logic           close_s;
  logic [FW-1:0]  slot_wr_s;
  logic [FW-1:0]  first_s;

  // in_ready never looks at in_valid: only the state and the consumer's out_ready
  assign in_ready  = (state_r == FILL) | out_ready;
  assign accept_s  = in_valid & in_ready;
  assign take_s    = valid_r & out_ready;
  assign close_s   = (idx_r == LAST_IDX) | in_last;

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_count = count_r;

  // Buffer with the incoming pair written into the current slot
  always_comb begin
    slot_wr_s = data_r;
    for (int k = 0; k < N; k++) begin
      if (idx_r == CW'(k)) begin
        slot_wr_s[k*SW +: SW] = {in_b, in_a};
      end else begin
        slot_wr_s[k*SW +: SW] = data_r[k*SW +: SW];
      end
    end
  end

  // Fresh frame holding only the incoming pair in slot 0
  always_comb begin
    first_s         = {FW{1'b0}};
    first_s[SW-1:0] = {in_b, in_a};
  end

  // Frame assembly and output handshake state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FILL;
      idx_r   <= ZERO_IDX;
      data_r  <= {FW{1'b0}};
      count_r <= ZERO_IDX;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (accept_s) begin
            data_r <= slot_wr_s;
            idx_r  <= idx_r + ONE_IDX;
            if (close_s) begin
              state_r <= HOLD;
              valid_r <= 1'b1;
              count_r <= idx_r + ONE_IDX;
            end else begin
              state_r <= FILL;
            end
          end else begin
            state_r <= FILL;
          end
        end
        HOLD: begin
          if (take_s) begin
            if (accept_s) begin
              // the pair accepted alongside the take opens the next frame
              data_r <= first_s;
              idx_r  <= ONE_IDX;
              if (SINGLE || in_last) begin
                state_r <= HOLD;
                valid_r <= 1'b1;
                count_r <= ONE_IDX;
              end else begin
                state_r <= FILL;
                valid_r <= 1'b0;
                count_r <= ZERO_IDX;
              end
            end else begin
              state_r <= FILL;
              idx_r   <= ZERO_IDX;
              data_r  <= {FW{1'b0}};
              count_r <= ZERO_IDX;
              valid_r <= 1'b0;
            end
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r <= FILL;
          idx_r   <= ZERO_IDX;
          data_r  <= {FW{1'b0}};
          count_r <= ZERO_IDX;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_packer.sv
// Randomized and directed bench for mac_operand_packer with a queue-based scoreboard.
module tb_mac_operand_packer;

  localparam int N = 4;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = 8'h00;
  logic [7:0]  in_b = 8'h00;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [2:0]  out_count;

  mac_operand_packer #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_mode = 1;
  int stalls = 0;
  int pushed = 0;
  int frames_seen = 0;
  int rise_q[$];
  logic [63:0] exp_data_q[$];
  int          exp_cnt_q[$];
  logic [7:0]  cur_a[$];
  logic [7:0]  cur_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: frame value is the plain positional sum of accepted pairs
  function automatic logic [63:0] pack_frame();
    logic [63:0] f;
    f = 64'h0;
    for (int k = 0; k < cur_a.size(); k++) begin
      f = f | ({56'h0, cur_a[k]} << (16 * k)) | ({56'h0, cur_b[k]} << (16 * k + 8));
    end
    return f;
  endfunction

  task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input logic last);
    cur_a.push_back(a);
    cur_b.push_back(b);
    if (cur_a.size() == N || last) begin
      exp_data_q.push_back(pack_frame());
      exp_cnt_q.push_back(cur_a.size());
      pushed++;
      cur_a.delete();
      cur_b.delete();
    end
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
    int t;
    logic accepted;
    t = 0;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    while (!accepted && t < 200) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      else begin
        stalls++;
        t++;
      end
    end
    chk("accept_timeout", accepted, 1'b1);
    if (accepted) model_accept(a, b, last);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int t;
    rdy_mode = 1;
    t = 0;
    while (exp_data_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_empty", exp_data_q.size(), 0);
  endtask

  // Consumer: out_ready pattern selected by rdy_mode
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: protocol rules, hold stability and scoreboard pops
  initial begin
    logic        prev_valid;
    logic        prev_taken;
    logic [63:0] prev_data;
    logic [2:0]  prev_count;
    prev_valid = 1'b0;
    prev_taken = 1'b0;
    prev_data = 64'h0;
    prev_count = 3'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        chk("in_ready_rule", in_ready, out_valid ? out_ready : 1'b1);
        if (prev_valid && !prev_taken) begin
          chk("hold_valid", out_valid, 1'b1);
          chk("hold_data", out_data, prev_data);
          chk("hold_count", out_count, prev_count);
        end
        if (out_valid && !prev_valid) rise_q.push_back(cyc);
        if (out_valid && out_ready) begin
          frames_seen++;
          if (exp_data_q.size() == 0) begin
            chk("unexpected_frame", 1'b1, 1'b0);
          end else begin
            chk("frame_data", out_data, exp_data_q.pop_front());
            chk("frame_count", out_count, exp_cnt_q.pop_front());
          end
        end
        prev_valid = out_valid;
        prev_taken = out_valid && out_ready;
        prev_data = out_data;
        prev_count = out_count;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int s0;
    // reset held with in_valid asserted
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_a = 8'h5A;
    in_b = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, 64'h0);
      chk("rst_count", out_count, 3'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // full frame
    rdy_mode = 1;
    send_pair(8'h03, 8'h06, 1'b0);
    send_pair(8'hAB, 8'h02, 1'b0);
    send_pair(8'h03, 8'h06, 1'b0);
    send_pair(8'hAB, 8'h02, 1'b0);
    drain();

    // early termination, then a 1-pair frame from idx 0
    send_pair(8'hFF, 8'hFF, 1'b0);
    send_pair(8'h08, 8'h05, 1'b1);
    send_pair(8'h77, 8'h88, 1'b1);
    drain();

    // backpressure: frame held while a pair waits, then lands in slot 0
    rdy_mode = 0;
    @(posedge clk);
    #2;
    send_pair(8'h03, 8'h06, 1'b0);
    send_pair(8'hAB, 8'h02, 1'b0);
    send_pair(8'h03, 8'h06, 1'b0);
    send_pair(8'hAB, 8'h02, 1'b0);
    s0 = stalls;
    fork
      send_pair(8'h5A, 8'h3C, 1'b0);
      begin
        repeat (6) @(posedge clk);
        rdy_mode = 1;
      end
    join
    chk("bp_stalled_5", (stalls - s0) >= 5, 1'b1);
    send_pair(8'h01, 8'h02, 1'b0);
    send_pair(8'h03, 8'h04, 1'b0);
    send_pair(8'h05, 8'h06, 1'b0);
    drain();

    // back-to-back streaming
    repeat (2) @(posedge clk);
    #1;
    rise_q.delete();
    s0 = stalls;
    for (int i = 0; i < 8; i++) send_pair(8'(i * 17 + 1), 8'(i * 29 + 3), 1'b0);
    drain();
    chk("b2b_frames", rise_q.size(), 2);
    if (rise_q.size() == 2) chk("b2b_spacing", rise_q[1] - rise_q[0], 4);
    chk("b2b_no_stall", stalls - s0, 0);

    // asynchronous reset mid-frame
    send_pair(8'h11, 8'h22, 1'b0);
    send_pair(8'h33, 8'h44, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", out_data, 64'h0);
    chk("async_rst_count", out_count, 3'd0);
    chk("async_rst_valid", out_valid, 1'b0);
    #1;
    rst_n = 1'b1;
    cur_a.delete();
    cur_b.delete();
    @(posedge clk);
    #1;
    send_pair(8'hC1, 8'hC2, 1'b0);
    send_pair(8'hC3, 8'hC4, 1'b0);
    send_pair(8'hC5, 8'hC6, 1'b0);
    send_pair(8'hC7, 8'hC8, 1'b0);
    drain();

    // randomized traffic with random backpressure and gaps
    rdy_mode = 2;
    repeat (120) begin
      send_pair(8'($urandom), 8'($urandom), $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    send_pair(8'h9E, 8'h9F, 1'b1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("frames_total", frames_seen, pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_operand_packer.md
Name: mac_operand_packer

Overview:
Upstream feeder for mult_accumulate. Accepts 8-bit operand pairs (a, b) one per cycle over a valid/ready stream and packs N pairs into the 16*N-bit operand bus that mult_accumulate consumes. Presents each complete frame with an out_valid/out_ready handshake and holds it until taken. Supports early frame termination with zero padding, and back-to-back frames with no bubble.

Parameters:
N, 4, number of operand pairs per frame; must be >= 1
W, 8, operand width in bits; frame slot width is 2*W

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_a/in_b/in_last carry a valid pair
in_ready  output  1  packer can accept a pair this cycle
in_a  input  W  first operand of pair
in_b  input  W  second operand of pair
in_last  input  1  this pair closes the frame early; unused slots are zero
out_valid  output  1  out_data holds a complete frame
out_ready  input  1  consumer takes the frame this cycle
out_data  output  2*W*N  packed frame to mult_accumulate In port
out_count  output  $clog2(N)+1  number of valid pairs in the presented frame, 1..N

Behaviour:
- Reset (rst_n=0, async): state=FILL, slot index=0, out_data=0, out_count=0, out_valid=0, in_ready=1 once rst_n=1.
- Slot packing: pair k goes to out_data[2Wk+W-1:2Wk]=in_a and out_data[2Wk+2W-1:2Wk+W]=in_b. Slot 0 is the LSBs.
- Input handshake: a pair is accepted when in_valid && in_ready at a clk edge. No combinational path from in_valid to in_ready.
- Output handshake: a frame is taken when out_valid && out_ready at a clk edge. Once asserted, out_data and out_count stay stable until taken.
- States:
  - FILL: in_ready=1, out_valid=0.
    - Each accepted pair writes slot idx, then idx++.
    - If the accepted pair has idx==N-1 or in_last=1, go to HOLD next cycle. Set out_valid=1 and out_count=idx+1.
    - Slots above the last written slot are zero.
  - HOLD: out_valid=1, in_ready=out_ready (combinational from out_ready only).
    - Take without a new pair: clear buffer to 0, idx=0, out_count=0, go to FILL.
    - Take with a simultaneous input accept: clear buffer, write the new pair into slot 0, idx=1.
      - If N==1 or in_last=1, stay in HOLD with the new frame (out_count=1).
      - Otherwise go to FILL.
    - No take: hold everything. in_ready=0, so no pairs are lost.
- in_last on the pair that fills slot N-1 is redundant and behaves like a full frame.
- in_last arriving with idx==0 produces a 1-pair frame.
- Throughput: sustained streaming with out_ready=1 gives one frame per N cycles, with no idle cycles between frames.
- Latency: out_valid rises on the clk edge that accepts the closing pair, so it is visible the next cycle.
- Mid-operation reset: a partial or held frame is discarded. All outputs return to reset values immediately, asynchronously, independent of clk.
- No data-dependent arithmetic. All index and count arithmetic is unsigned and sized to $clog2(N)+1 bits to avoid wrap at N.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, out_data=0, out_count=0 throughout. in_ready=1 on the first cycle after release.
- Full frame, N=4: send pairs (03,06),(AB,02),(03,06),(AB,02) with out_ready=1 -> out_valid for 1 cycle, out_data=64'h02AB_0603_02AB_0603, out_count=4.
- Early termination: send (FF,FF) then (08,05) with in_last=1 -> out_data=64'h0000_0000_0508_FFFF, out_count=2. Next frame starts from slot 0 with zeroed upper slots.
- Backpressure: complete the frame from the full-frame scenario with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_data stable, no pair accepted. Raise out_ready -> frame taken, and the pair presented that cycle lands in slot 0 of the next frame.
- Back-to-back: stream 8 pairs continuously with out_ready=1 -> two frames; the second out_valid rises exactly 4 cycles after the first, with zero idle cycles on in_ready.
- Reset mid-frame: accept 2 pairs, pulse rst_n low asynchronously between clk edges -> outputs cleared immediately. The next 4 pairs form a clean frame with out_count=4.
